// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// ext_mem_arbiter : two-master round-robin sequencer for the external data memory
// Revision 1.0
// ============================================================================
module ext_mem_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_req,
   input  logic        m0_wr,
   input  logic [1:0]  m0_size,
   input  logic [15:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_wr,
   input  logic [1:0]  m1_size,
   input  logic [15:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [1:0]  mem_size,
   output logic [15:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_WD_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_WD_ONE  = CNT_W'(1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [15:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  wd_q, wd_d;
   logic [31:0]       rdata0_q, rdata0_d;
   logic [31:0]       rdata1_q, rdata1_d;

   logic              gnt_w;
   logic              sel_w;
   logic              done_w;
   logic              err_w;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      wr_d     = wr_q;
      size_d   = size_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wd_d     = wd_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      gnt_w    = 1'b0;
      sel_w    = 1'b0;
      done_w   = 1'b0;
      err_w    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               gnt_w   = 1'b1;
               // On contention the master that was not served last wins
               sel_w   = (m0_req && m1_req) ? ~last_q : m1_req;
               owner_d = sel_w;
               wr_d    = sel_w ? m1_wr    : m0_wr;
               size_d  = sel_w ? m1_size  : m0_size;
               addr_d  = sel_w ? m1_addr  : m0_addr;
               wdata_d = sel_w ? m1_wdata : m0_wdata;
               wd_d    = '0;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (mem_ready) begin
               wd_d    = '0;
               state_d = S_DATA;
            end else if (wd_q == C_WD_LAST) begin
               done_w  = 1'b1;
               err_w   = 1'b1;
               last_d  = owner_q;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + C_WD_ONE;
            end
         end
         S_DATA: begin
            // Once the address is accepted the memory must finish; no watchdog here
            if (mem_ready) begin
               done_w  = 1'b1;
               last_d  = owner_q;
               state_d = S_IDLE;
               if (!wr_q) begin
                  if (owner_q) rdata1_d = mem_rdata;
                  else         rdata0_d = mem_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;   // "m1 served last" so m0 wins the first tie
         wr_q     <= 1'b0;
         size_q   <= 2'd0;
         addr_q   <= 16'd0;
         wdata_q  <= 32'd0;
         wd_q     <= '0;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wd_q     <= wd_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   // Pulses are masked while reset is held so an abandoned transfer never completes
   assign m0_gnt    = rst_n & gnt_w & ~sel_w;
   assign m1_gnt    = rst_n & gnt_w &  sel_w;
   assign m0_done   = rst_n & done_w & ~owner_q;
   assign m1_done   = rst_n & done_w &  owner_q;
   assign m0_err    = m0_done & err_w;
   assign m1_err    = m1_done & err_w;
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

   assign mem_rd_en = (state_q == S_ADDR);
   assign mem_wr_en = (state_q == S_ADDR) & wr_q;
   assign mem_size  = size_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ext_mem_arbiter : directed table, corner sequences and random traffic
// Revision 1.0
// ============================================================================
module tb_ext_mem_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_wr, m0_gnt, m0_done, m0_err;
   logic [1:0]  m0_size;
   logic [15:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic        m1_req, m1_wr, m1_gnt, m1_done, m1_err;
   logic [1:0]  m1_size;
   logic [15:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic        mem_rd_en, mem_wr_en, mem_ready;
   logic [1:0]  mem_size;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   ext_mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err),
      .m1_rdata(m1_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [15:0] addr;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      int          m;
      logic        wr;
      logic [1:0]  size;
      logic [15:0] addr;
      logic [31:0] wdata;
      int          ast;
      int          dst;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_rden;
   } vec_t;

   logic [7:0]  mem [0:65535];
   op_t         q0[$], q1[$];
   int          n_chk = 0, n_fail = 0;

   // transaction-level reference state
   bit          busy, in_data, owner, last;
   int          acyc;
   op_t         cur;
   logic [31:0] exp_rd [2];

   // memory slave state
   bit          mem_dp;
   logic [15:0] ml_addr;
   logic [1:0]  ml_size;
   logic        ml_wr;
   logic [31:0] ml_wdata;
   int          astall, dstall;

   // observations of the DUT
   int          cyc, gnt_cyc, done_cyc, rden_cnt, done_who;
   logic        done_err;
   int          gnt_log[$], gnt_tlog[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rdw(input logic [15:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[16'(a + 16'(i))];
      return w;
   endfunction

   task automatic commit(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] d);
      int nb;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) mem[16'(a + 16'(i))] = d[8*i +: 8];
   endtask

   function automatic op_t rand_op();
      op_t o;
      o.wr    = 1'($urandom_range(0, 1));
      o.size  = 2'($urandom_range(0, 2));
      o.addr  = 16'h0100 + 16'($urandom_range(0, 63));
      o.wdata = $urandom;
      return o;
   endfunction

   // One clock cycle: called at posedge+1, returns at the next posedge+1
   task automatic tick();
      logic [7:0] a, e;
      int   win;
      bit   abort, fin;
      win = -1; abort = 0; fin = 0; e = '0;

      m0_req = (q0.size() > 0);
      m1_req = (q1.size() > 0);
      {m0_wr, m0_size, m0_addr, m0_wdata} = m0_req ? q0[0] : op_t'({$urandom, $urandom});
      {m1_wr, m1_size, m1_addr, m1_wdata} = m1_req ? q1[0] : op_t'({$urandom, $urandom});

      if (mem_dp) begin
         mem_rdata = rdw(ml_addr);
         if (dstall > 0) begin mem_ready = 1'b0; dstall--; end
         else mem_ready = 1'b1;
      end else begin
         mem_rdata = $urandom;
         if (mem_rd_en) begin
            if (astall > 0) begin mem_ready = 1'b0; astall--; end
            else mem_ready = 1'b1;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
      end
      #2;

      if (!busy) begin
         if (m0_req && m1_req) win = last ? 0 : 1;
         else if (m0_req)      win = 0;
         else if (m1_req)      win = 1;
         if (win == 0) e[7] = 1'b1;
         if (win == 1) e[6] = 1'b1;
      end else if (!in_data) begin
         acyc++;
         e[1] = 1'b1;
         e[0] = cur.wr;
         if (!mem_ready && acyc == TO) begin
            abort = 1;
            e[5 - int'(owner)] = 1'b1;
            e[3 - int'(owner)] = 1'b1;
         end
      end else if (mem_ready) begin
         fin = 1;
         e[5 - int'(owner)] = 1'b1;
      end

      a = {m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, mem_rd_en, mem_wr_en};
      check("ctrl", 128'(a), 128'(e));
      if (busy) check("bus", {mem_addr, mem_size, mem_wdata}, {cur.addr, cur.size, cur.wdata});
      check("rdata", {m0_rdata, m1_rdata}, {exp_rd[0], exp_rd[1]});

      if (mem_rd_en) rden_cnt++;
      if (m0_gnt || m1_gnt) begin
         gnt_cyc = cyc;
         gnt_log.push_back(m1_gnt ? 1 : 0);
         gnt_tlog.push_back(cyc);
      end
      if (m0_done || m1_done) begin
         done_cyc = cyc;
         done_who = m1_done ? 1 : 0;
         done_err = m0_err | m1_err;
      end

      if (win >= 0) begin
         busy = 1; owner = (win == 1); in_data = 0; acyc = 0;
         if (win == 1) cur = q1.pop_front();
         else          cur = q0.pop_front();
      end else if (busy && !in_data) begin
         if (mem_ready) in_data = 1;
         else if (abort) begin busy = 0; last = owner; astall = 0; dstall = 0; end
      end else if (fin) begin
         busy = 0; last = owner; astall = 0; dstall = 0;
         if (!cur.wr) exp_rd[int'(owner)] = rdw(cur.addr);
      end

      if (mem_dp) begin
         if (mem_ready) begin
            if (ml_wr) commit(ml_addr, ml_size, ml_wdata);
            mem_dp = 0;
         end
      end else if (mem_rd_en && mem_ready) begin
         mem_dp = 1; ml_addr = mem_addr; ml_size = mem_size;
         ml_wr = mem_wr_en; ml_wdata = mem_wdata;
      end

      cyc++;
      @(posedge clk); #1;
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((busy || q0.size() > 0 || q1.size() > 0) && k < maxc) begin
         tick();
         k++;
      end
      check("drain_bound", 128'(busy || q0.size() > 0 || q1.size() > 0), 128'(0));
   endtask

   task automatic model_reset();
      busy = 0; in_data = 0; owner = 0; last = 1; acyc = 0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      mem_dp = 0; astall = 0; dstall = 0;
      q0.delete(); q1.delete();
   endtask

   function automatic logic [127:0] all_outs();
      return 128'({m0_gnt, m0_done, m0_err, m0_rdata, m1_gnt, m1_done, m1_err, m1_rdata,
                   mem_rd_en, mem_wr_en, mem_size, mem_addr, mem_wdata});
   endfunction

   vec_t vecs[10];

   initial begin
      op_t o;
      vecs[0] = '{0, 1'b0, 2'd2, 16'h0010, 32'h0,        0,  0, 32'h11223344, 1'b0, 2,  1};
      vecs[1] = '{1, 1'b1, 2'd1, 16'h0020, 32'h1234BEEF, 0,  0, 32'h00000000, 1'b0, 2,  1};
      vecs[2] = '{1, 1'b0, 2'd2, 16'h0020, 32'h0,        0,  0, 32'h0000BEEF, 1'b0, 2,  1};
      vecs[3] = '{0, 1'b0, 2'd2, 16'h0010, 32'h0,        5,  0, 32'h11223344, 1'b0, 7,  6};
      vecs[4] = '{0, 1'b0, 2'd2, 16'h0030, 32'h0,        20, 0, 32'h11223344, 1'b1, 16, 16};
      vecs[5] = '{1, 1'b0, 2'd2, 16'h0030, 32'h0,        0,  3, 32'hDDCCBBAA, 1'b0, 5,  1};
      vecs[6] = '{0, 1'b1, 2'd0, 16'h0031, 32'hFFFFFF5A, 0,  0, 32'h11223344, 1'b0, 2,  1};
      vecs[7] = '{0, 1'b0, 2'd2, 16'h0030, 32'h0,        0,  0, 32'hDDCC5AAA, 1'b0, 2,  1};
      vecs[8] = '{1, 1'b0, 2'd2, 16'hFFFE, 32'h0,        0,  0, 32'h04030201, 1'b0, 2,  1};
      vecs[9] = '{1, 1'b0, 2'd2, 16'h0011, 32'h0,        0,  0, 32'h00112233, 1'b0, 2,  1};

      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      {mem[16'h10], mem[16'h11], mem[16'h12], mem[16'h13]} = {8'h44, 8'h33, 8'h22, 8'h11};
      {mem[16'h30], mem[16'h31], mem[16'h32], mem[16'h33]} = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      {mem[16'hFFFE], mem[16'hFFFF], mem[16'h0], mem[16'h1]} = {8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 16'h0100; i < 16'h0148; i++) mem[i] = 8'($urandom);

      rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      {m0_wr, m0_size, m0_addr, m0_wdata} = '0;
      {m1_wr, m1_size, m1_addr, m1_wdata} = '0;
      model_reset();
      cyc = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", all_outs(), 128'(0));
      rst_n = 1'b1;

      // directed table
      for (int i = 0; i < 10; i++) begin
         o = '{wr: vecs[i].wr, size: vecs[i].size, addr: vecs[i].addr, wdata: vecs[i].wdata};
         rden_cnt = 0; done_who = -1; gnt_cyc = -1; done_cyc = -1; done_err = 1'bx;
         if (vecs[i].m == 0) q0.push_back(o);
         else                q1.push_back(o);
         astall = vecs[i].ast;
         dstall = vecs[i].dst;
         drain(100);
         check($sformatf("v%0d_rdata", i), vecs[i].m ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), 128'(done_err), 128'(vecs[i].exp_err));
         check($sformatf("v%0d_owner", i), 128'(done_who), 128'(vecs[i].m));
         check($sformatf("v%0d_latency", i), 128'(done_cyc - gnt_cyc), 128'(vecs[i].exp_lat));
         check($sformatf("v%0d_rden_cycles", i), 128'(rden_cnt), 128'(vecs[i].exp_rden));
      end

      // both masters requesting continuously: strict alternation, 3 cycles apart
      gnt_log.delete(); gnt_tlog.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back('{wr: 1'b0, size: 2'd2, addr: 16'h0010, wdata: 32'h0});
         q1.push_back('{wr: 1'b1, size: 2'd2, addr: 16'h0040 + 16'(4*i), wdata: $urandom});
      end
      drain(100);
      check("alt_count", 128'(gnt_log.size()), 128'(6));
      for (int i = 0; i < gnt_log.size(); i++) begin
         check($sformatf("alt_owner%0d", i), 128'(gnt_log[i]), 128'(i % 2));
         if (i > 0) check($sformatf("alt_gap%0d", i), 128'(gnt_tlog[i] - gnt_tlog[i-1]), 128'(3));
      end

      // leave m0 as last served, then reset in the data phase of an m0 write
      q0.push_back('{wr: 1'b0, size: 2'd2, addr: 16'h0030, wdata: 32'h0});
      drain(100);
      q0.push_back('{wr: 1'b1, size: 2'd2, addr: 16'h0050, wdata: 32'hCAFEF00D});
      dstall = 4;
      begin
         int k;
         k = 0;
         while (!(busy && in_data) && k < 20) begin tick(); k++; end
         check("reach_data", 128'(busy && in_data), 128'(1));
      end
      rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1; mem_ready = 1'b1; mem_rdata = $urandom;
      #2;
      check("rst_no_done", 128'({m0_done, m1_done, m0_gnt, m1_gnt}), 128'(0));
      @(posedge clk); #1;
      check("rst_mid_outputs", all_outs(), 128'(0));
      model_reset();
      rst_n = 1'b1;
      gnt_log.delete(); gnt_tlog.delete();
      q0.push_back('{wr: 1'b0, size: 2'd2, addr: 16'h0010, wdata: 32'h0});
      q1.push_back('{wr: 1'b0, size: 2'd2, addr: 16'h0030, wdata: 32'h0});
      drain(100);
      check("post_reset_first", 128'(gnt_log.size() > 0 ? gnt_log[0] : -1), 128'(0));
      check("post_reset_m0_rdata", m0_rdata, 32'h11223344);

      // random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_op());
         if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_op());
         if (busy && !in_data && acyc == 0 && astall == 0 && dstall == 0) begin
            astall = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 2);
            dstall = $urandom_range(0, 2);
         end
         tick();
      end
      drain(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
